// File: rtl/motor_pkg.sv
`timescale 1ns/1ps
// Shared motor-control definitions: command width, PWM defaults, direction
// encoding and the H-bridge PWM state type.
package motor_pkg;

    localparam int CMD_W            = 16;
    localparam int DEFAULT_PERIOD   = 4000;
    localparam int DEFAULT_DUTY_MAX = 4000;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [1:0] {
        S_OFF,
        S_FWD,
        S_REV,
        S_DEAD
    } pwm_state_t;

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Generic two-flop synchronizer with asynchronous active-low reset.
// RESET_VAL selects the idle level, e.g. 1 for active-low inputs.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hbridge_pwm_driver.sv
`timescale 1ns/1ps
// H-bridge PWM driver: signed duty command -> in1/in2 PWM with reversal dead time.
// Optional fault latch enabled by defining HBRIDGE_PWM_DRIVER_FAULT_LATCH_EN.
module hbridge_pwm_driver
    import motor_pkg::*;
#(
    parameter int PERIOD   = DEFAULT_PERIOD,
    parameter int DUTY_MAX = DEFAULT_DUTY_MAX,
    parameter int DEADTIME = 200,
    parameter int CNT_W    = 13
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic signed [CMD_W-1:0] duty_cmd,
    input  logic                    fault_n,
    input  logic                    fault_clr,
    output logic                    in1,
    output logic                    in2,
    output logic                    pwm_sync,
    output logic                    dir_o,
    output logic [CNT_W-1:0]        duty_mag_o,
    output logic                    fault_latched
);

    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    // 17-bit magnitude so that -32768 folds to +32768 before the clamp.
    function automatic logic [CNT_W-1:0] clamp_mag(input logic signed [CMD_W-1:0] cmd);
        logic signed [CMD_W:0] wide;
        logic        [CMD_W:0] abs_val;
        wide    = {cmd[CMD_W-1], cmd};
        abs_val = wide[CMD_W] ? $unsigned(-wide) : $unsigned(wide);
        if (abs_val > (CMD_W+1)'(DUTY_MAX))
            return CNT_W'(DUTY_MAX);
        return abs_val[CNT_W-1:0];
    endfunction

    pwm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  mag_q, mag_d, cmd_mag;
    logic              dir_q, dir_d, cmd_dir;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              boundary, drive_ok, in1_d, in2_d;

    assign boundary = (cnt_q == CNT_W'(PERIOD - 1));
    assign cmd_mag  = clamp_mag(duty_cmd);
    assign cmd_dir  = duty_cmd[CMD_W-1];

`ifdef HBRIDGE_PWM_DRIVER_FAULT_LATCH_EN
    logic fault_n_s;
    logic fault_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_fault_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (fault_n),
        .q       (fault_n_s)
    );

    // A clear is honoured only once the synchronized fault has gone away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fault_q <= 1'b0;
        else if (!fault_n_s)
            fault_q <= 1'b1;
        else if (fault_clr)
            fault_q <= 1'b0;
    end

    assign fault_latched = fault_q;
    assign drive_ok      = enable && fault_n_s && !fault_q;
`else
    logic unused_fault_inputs;
    assign unused_fault_inputs = fault_n ^ fault_clr;
    assign fault_latched       = 1'b0;
    assign drive_ok            = enable;
`endif

    // Period counter and state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            state_q <= S_OFF;
            mag_q   <= '0;
            dir_q   <= DIR_FWD;
            dead_q  <= '0;
        end else begin
            cnt_q   <= boundary ? '0 : cnt_q + 1'b1;
            state_q <= state_d;
            mag_q   <= mag_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mag_d   = mag_q;
        dead_d  = '0;
        case (state_q)
            S_OFF: begin
                if (boundary && cmd_mag != '0) begin
                    state_d = cmd_dir ? S_REV : S_FWD;
                    dir_d   = cmd_dir;
                    mag_d   = cmd_mag;
                end
            end
            S_FWD, S_REV: begin
                if (boundary) begin
                    if (cmd_mag == '0) begin
                        state_d = S_OFF;
                        dir_d   = DIR_FWD;
                        mag_d   = '0;
                    end else if (cmd_dir == dir_q) begin
                        mag_d = cmd_mag;
                    end else begin
                        state_d = S_DEAD;
                        dir_d   = cmd_dir;
                        mag_d   = cmd_mag;
                    end
                end
            end
            S_DEAD: begin
                // dir_q/mag_q already hold the target; enter it mid-period.
                dead_d = dead_q + 1'b1;
                if (dead_q == DEAD_W'(DEADTIME - 1)) begin
                    state_d = dir_q ? S_REV : S_FWD;
                    dead_d  = '0;
                end
                if (boundary) begin
                    if (cmd_mag == '0) begin
                        state_d = S_OFF;
                        dir_d   = DIR_FWD;
                        mag_d   = '0;
                        dead_d  = '0;
                    end else begin
                        dir_d = cmd_dir;
                        mag_d = cmd_mag;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase

        if (!drive_ok) begin
            state_d = S_OFF;
            dir_d   = DIR_FWD;
            mag_d   = '0;
            dead_d  = '0;
        end

        in1_d = drive_ok && (state_q == S_FWD) && (cnt_q < mag_q);
        in2_d = drive_ok && (state_q == S_REV) && (cnt_q < mag_q);
    end

    // Registered bridge outputs: one cycle behind the compared count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in1      <= 1'b0;
            in2      <= 1'b0;
            pwm_sync <= 1'b0;
        end else begin
            in1      <= in1_d;
            in2      <= in2_d;
            pwm_sync <= (cnt_q == '0);
        end
    end

    assign dir_o      = dir_q;
    assign duty_mag_o = mag_q;

endmodule
